// File: rtl/simple_uart_pkg.sv
// ---------------------------------------------------------------------------
// simple_uart_pkg
// Shared definitions for the simple UART transmitter and receiver.
//   DATA_W    : payload width of one character
//   START_BIT : line level of the start bit
//   STOP_BIT  : line level of the stop bit(s), also the idle level
//   state_t   : frame state machine encoding
// Optional feature macro: SIMPLE_UART_TX_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package simple_uart_pkg;

    localparam int   DATA_W    = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SIMPLE_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps, pulsing bit_done
// for one cycle on the last count of every bit period.
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, clears the counter
//   clear    : synchronous hold-at-zero, used while the line is idle
//   bit_done : high during the final cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running bit timer; wrapping at LAST and holding at zero while
    // cleared means every state entry sees a fresh count of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bit_done = (r_count == LAST);

endmodule

// File: rtl/simple_uart_tx.sv
// ---------------------------------------------------------------------------
// simple_uart_tx
// 8N1/8N2 UART transmitter (optionally 8E1/8E2).
// Frame: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Parameters:
//   CLKS_PER_BIT : clocks per serial bit (2..65535)
//   STOP_BITS    : 1 or 2
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, aborts any frame
//   data       : byte to send, latched on acceptance
//   data_valid : data holds a byte to send
//   ready      : a byte is accepted this cycle if data_valid is high
//   tx         : serial line, idle high, driven from a register
//   busy       : a frame is in progress
// Optional feature: define SIMPLE_UART_TX_PARITY_EN for an even-parity bit.
// ---------------------------------------------------------------------------
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    state_t            r_state;
    logic [2:0]        r_bitCnt;
    logic              r_stopCnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
`ifdef SIMPLE_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_bitDone;
    logic w_lastStop;
    logic w_accept;

    // The bit timer is held at zero while idle so the start bit gets a full
    // period from the cycle after acceptance.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state == IDLE),
        .bit_done(w_bitDone)
    );

    // Final cycle of the final stop bit: a new byte may be taken here so
    // consecutive frames abut with no idle gap.
    assign w_lastStop = (r_state == STOP) && (r_stopCnt == 1'(STOP_BITS - 1)) && w_bitDone;
    assign ready      = (r_state == IDLE) || w_lastStop;
    assign busy       = (r_state != IDLE);
    assign w_accept   = data_valid && ready;
    assign tx         = r_tx;

    // Frame sequencer. The line level for the next bit is registered at the
    // same edge as the state change, so tx never depends on an input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_shift   <= '0;
            r_tx      <= STOP_BIT;
`ifdef SIMPLE_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_shift  <= data;
                        r_tx     <= START_BIT;
`ifdef SIMPLE_UART_TX_PARITY_EN
                        r_parity <= ^data;
`endif
                    end
                end
                START: begin
                    if (w_bitDone) begin
                        r_state  <= DATA;
                        r_bitCnt <= '0;
                        r_tx     <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
`ifdef SIMPLE_UART_TX_PARITY_EN
                            r_state   <= PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= STOP;
                            r_stopCnt <= 1'b0;
                            r_tx      <= STOP_BIT;
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
`ifdef SIMPLE_UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bitDone) begin
                        r_state   <= STOP;
                        r_stopCnt <= 1'b0;
                        r_tx      <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    if (w_bitDone) begin
                        if (r_stopCnt == 1'(STOP_BITS - 1)) begin
                            if (w_accept) begin
                                r_state  <= START;
                                r_shift  <= data;
                                r_tx     <= START_BIT;
`ifdef SIMPLE_UART_TX_PARITY_EN
                                r_parity <= ^data;
`endif
                            end else begin
                                r_state <= IDLE;
                                r_tx    <= STOP_BIT;
                            end
                        end else begin
                            r_stopCnt <= r_stopCnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= STOP_BIT;
                end
            endcase
        end
    end

endmodule
